// File: rtl/traffic_intersection_ctrl.sv
// Two-phase intersection sequencer driving two semaforo lights (A and B).
// Handles green dwell limits, all-red clearance, feedback watchdog and a sticky safety fault.
module traffic_intersection_ctrl #(
    parameter int MIN_GREEN  = 20000,
    parameter int MAX_GREEN  = 60000,
    parameter int ALLRED     = 5000,
    parameter int WD_TIMEOUT = 40000,
    parameter int CW         = 16
) (
    input  logic       clklf,
    input  logic       reset,
    input  logic       en,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       a_green,
    input  logic       a_yellow,
    input  logic       a_red,
    input  logic       b_green,
    input  logic       b_yellow,
    input  logic       b_red,
    output logic       en_a,
    output logic       en_b,
    output logic       set_a,
    output logic       set_b,
    output logic       change_a,
    output logic       change_b,
    output logic       fault,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT      = 4'd1,
        A_GREEN   = 4'd2,
        A_CLEAR   = 4'd3,
        ALLRED_AB = 4'd4,
        B_GRANT   = 4'd5,
        B_GREEN   = 4'd6,
        B_CLEAR   = 4'd7,
        ALLRED_BA = 4'd8,
        A_GRANT   = 4'd9,
        FAULT     = 4'd15
    } state_t;

    localparam logic [CW-1:0] MIN_LIM = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_LIM = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] AR_LIM  = CW'(ALLRED - 1);
    localparam logic [CW-1:0] WD_LIM  = CW'(WD_TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    req_vec, pend_reg, grant_entry;
    logic          conflict, in_service, wd_state;

    logic en_a_reg, en_b_reg, set_a_reg, set_b_reg;
    logic change_a_reg, change_b_reg, fault_reg;
    logic [3:0] phase_reg;

    // Both approaches showing go/caution, or a lamp showing all three colours.
    assign conflict   = ((a_green | a_yellow) & (b_green | b_yellow))
                      | (a_green & a_yellow & a_red)
                      | (b_green & b_yellow & b_red);
    assign in_service = (state_reg >= A_GREEN) && (state_reg <= A_GRANT);
    assign wd_state   = (state_reg == INIT)    || (state_reg == A_CLEAR) ||
                        (state_reg == B_GRANT) || (state_reg == B_CLEAR) ||
                        (state_reg == A_GRANT);

    always_comb begin
        state_next = state_reg;
        if (state_reg == FAULT) begin
            state_next = FAULT;
        end else if (in_service && conflict) begin
            state_next = FAULT;
        end else if (wd_state && (cnt_reg == WD_LIM)) begin
            state_next = FAULT;
        end else if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:      state_next = INIT;
                INIT:      if (a_green && b_red) state_next = A_GREEN;
                A_GREEN:   if ((cnt_reg >= MIN_LIM && pend_reg[1]) || cnt_reg >= MAX_LIM)
                               state_next = A_CLEAR;
                A_CLEAR:   if (a_red) state_next = ALLRED_AB;
                ALLRED_AB: if (cnt_reg == AR_LIM) state_next = B_GRANT;
                B_GRANT:   if (b_green) state_next = B_GREEN;
                B_GREEN:   if ((cnt_reg >= MIN_LIM && pend_reg[0]) || cnt_reg >= MAX_LIM)
                               state_next = B_CLEAR;
                B_CLEAR:   if (b_red) state_next = ALLRED_BA;
                ALLRED_BA: if (cnt_reg == AR_LIM) state_next = A_GRANT;
                A_GRANT:   if (a_green) state_next = A_GREEN;
                default:   state_next = FAULT;
            endcase
        end
    end

    always_ff @(posedge clklf) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (cnt_reg != '1)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign req_vec        = {req_b, req_a};
    assign grant_entry[0] = (state_next == A_GREEN) && (state_reg != A_GREEN);
    assign grant_entry[1] = (state_next == B_GREEN) && (state_reg != B_GREEN);

    // Entering the served green wins over a simultaneous new request.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pend
            logic pend_g_reg;
            always_ff @(posedge clklf) begin
                if (reset)
                    pend_g_reg <= 1'b0;
                else if (grant_entry[gi])
                    pend_g_reg <= 1'b0;
                else if (req_vec[gi])
                    pend_g_reg <= 1'b1;
            end
            assign pend_reg[gi] = pend_g_reg;
        end
    endgenerate

    // Outputs are a registered decode of the current state; cnt==0 marks a state's first cycle.
    always_ff @(posedge clklf) begin
        if (reset) begin
            en_a_reg     <= 1'b0;
            en_b_reg     <= 1'b0;
            set_a_reg    <= 1'b0;
            set_b_reg    <= 1'b0;
            change_a_reg <= 1'b0;
            change_b_reg <= 1'b0;
            fault_reg    <= 1'b0;
            phase_reg    <= 4'd0;
        end else begin
            en_a_reg     <= (state_reg != IDLE) && (state_reg != FAULT);
            en_b_reg     <= (state_reg != IDLE) && (state_reg != FAULT);
            set_a_reg    <= 1'b0;
            set_b_reg    <= (state_reg != IDLE) && (state_reg != FAULT);
            change_a_reg <= ((state_reg == A_CLEAR) || (state_reg == A_GRANT)) && (cnt_reg == '0);
            change_b_reg <= ((state_reg == B_CLEAR) || (state_reg == B_GRANT)) && (cnt_reg == '0);
            fault_reg    <= (state_reg == FAULT);
            phase_reg    <= state_reg;
        end
    end

    assign en_a     = en_a_reg;
    assign en_b     = en_b_reg;
    assign set_a    = set_a_reg;
    assign set_b    = set_b_reg;
    assign change_a = change_a_reg;
    assign change_b = change_b_reg;
    assign fault    = fault_reg;
    assign phase    = phase_reg;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with scaled timing and a behavioural light model.
module tb_traffic_intersection_ctrl;

    localparam int MIN_G   = 20;
    localparam int MAX_G   = 60;
    localparam int AR      = 5;
    localparam int WD      = 40;
    localparam int YEL_CYC = 3;

    logic clklf, reset, en, req_a, req_b;
    logic a_green, a_yellow, a_red, b_green, b_yellow, b_red;
    logic en_a, en_b, set_a, set_b, change_a, change_b, fault;
    logic [3:0] phase;

    logic force_conf, stuck_yel_a;
    int   n_vec, n_miss;

    traffic_intersection_ctrl #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .ALLRED(AR), .WD_TIMEOUT(WD), .CW(8)
    ) dut (
        .clklf(clklf), .reset(reset), .en(en), .req_a(req_a), .req_b(req_b),
        .a_green(a_green), .a_yellow(a_yellow), .a_red(a_red),
        .b_green(b_green), .b_yellow(b_yellow), .b_red(b_red),
        .en_a(en_a), .en_b(en_b), .set_a(set_a), .set_b(set_b),
        .change_a(change_a), .change_b(change_b), .fault(fault), .phase(phase)
    );

    initial begin
        clklf = 1'b0;
        forever #5 clklf = ~clklf;
    end

    // Light model: lamps come up per set_*, change turns green->yellow->red or red->green.
    typedef enum logic [1:0] {L_OFF, L_GRN, L_YEL, L_RED} lamp_t;
    lamp_t lamp_a, lamp_b;
    int    ytm_a, ytm_b;

    always_ff @(posedge clklf) begin
        if (reset || !en_a) begin
            lamp_a <= L_OFF;
            ytm_a  <= 0;
        end else if (lamp_a == L_OFF) lamp_a <= set_a ? L_RED : L_GRN;
        else if (change_a && lamp_a == L_GRN) begin
            lamp_a <= L_YEL;
            ytm_a  <= YEL_CYC;
        end else if (change_a && lamp_a == L_RED) lamp_a <= L_GRN;
        else if (lamp_a == L_YEL && !stuck_yel_a) begin
            if (ytm_a <= 1) lamp_a <= L_RED;
            else            ytm_a  <= ytm_a - 1;
        end
    end

    always_ff @(posedge clklf) begin
        if (reset || !en_b) begin
            lamp_b <= L_OFF;
            ytm_b  <= 0;
        end else if (lamp_b == L_OFF) lamp_b <= set_b ? L_RED : L_GRN;
        else if (change_b && lamp_b == L_GRN) begin
            lamp_b <= L_YEL;
            ytm_b  <= YEL_CYC;
        end else if (change_b && lamp_b == L_RED) lamp_b <= L_GRN;
        else if (lamp_b == L_YEL) begin
            if (ytm_b <= 1) lamp_b <= L_RED;
            else            ytm_b  <= ytm_b - 1;
        end
    end

    assign a_green  = (lamp_a == L_GRN) && !force_conf;
    assign a_yellow = (lamp_a == L_YEL) || force_conf;
    assign a_red    = (lamp_a == L_RED) && !force_conf;
    assign b_green  = (lamp_b == L_GRN) || force_conf;
    assign b_yellow = (lamp_b == L_YEL) && !force_conf;
    assign b_red    = (lamp_b == L_RED) && !force_conf;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic wait_phase(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && int'(phase) != target; i++) @(negedge clklf);
        chk(tag, int'(phase), target);
    endtask

    // Called on the first negedge showing phase 2; optionally pulses req_b at dwell count req_at.
    task automatic run_green(input int req_at, output int dur);
        dur = 0;
        for (int i = 0; i < 300 && phase == 4'd2; i++) begin
            dur++;
            req_b = (dur == req_at);
            @(negedge clklf);
        end
        req_b = 1'b0;
    endtask

    initial begin
        int dur, n;
        n_vec = 0; n_miss = 0;
        reset = 1'b1; en = 1'b0; req_a = 1'b0; req_b = 1'b0;
        force_conf = 1'b0; stuck_yel_a = 1'b0;
        repeat (3) @(posedge clklf);
        @(negedge clklf);
        chk("rst_phase", int'(phase), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_en_a", int'(en_a), 0);
        chk("rst_en_b", int'(en_b), 0);
        chk("rst_change", int'({change_a, change_b}), 0);
        reset = 1'b0;
        @(negedge clklf);
        chk("idle_hold", int'(phase), 0);

        en = 1'b1;
        wait_phase("init_phase", 1, 20);
        chk("init_set_a", int'(set_a), 0);
        chk("init_set_b", int'(set_b), 1);
        chk("init_en_ab", int'({en_a, en_b}), 3);
        wait_phase("a_green_entry", 2, 20);

        run_green(-1, dur);
        chk("a_green_max_dwell", dur, MAX_G);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (phase == 4'd4) break;
            if (change_a) n++;
            @(negedge clklf);
        end
        chk("change_a_pulses", n, 1);
        chk("allred_ab_entry", int'(phase), 4);
        n = 0;
        for (int i = 0; i < 100 && phase == 4'd4; i++) begin
            n++;
            @(negedge clklf);
        end
        chk("allred_ab_len", n, AR);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (phase == 4'd6) break;
            if (change_b) n++;
            @(negedge clklf);
        end
        chk("change_b_pulses", n, 1);
        chk("b_green_entry", int'(phase), 6);

        wait_phase("a_green_again", 2, 300);
        run_green(3, dur);
        chk("a_green_min_dwell", dur, MIN_G);
        wait_phase("b_green_2", 6, 300);
        wait_phase("a_green_3", 2, 300);
        run_green(25, dur);
        chk("a_green_late_req", dur, 27);

        wait_phase("b_green_3", 6, 300);
        force_conf = 1'b1;
        @(negedge clklf);
        chk("fault_lag", int'(fault), 0);
        @(negedge clklf);
        chk("fault_set", int'(fault), 1);
        chk("fault_phase", int'(phase), 15);
        chk("fault_en_off", int'({en_a, en_b}), 0);
        force_conf = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clklf);
        en = 1'b1;
        repeat (3) @(negedge clklf);
        chk("fault_sticky", int'(fault), 1);
        chk("fault_sticky_phase", int'(phase), 15);
        en = 1'b0;
        reset = 1'b1;
        @(negedge clklf);
        chk("fault_cleared", int'(fault), 0);
        chk("fault_cleared_phase", int'(phase), 0);

        reset = 1'b0;
        stuck_yel_a = 1'b1;
        en = 1'b1;
        wait_phase("wd_a_green", 2, 50);
        wait_phase("wd_a_clear", 3, 200);
        n = 0;
        for (int i = 0; i < 200 && phase == 4'd3; i++) begin
            n++;
            @(negedge clklf);
        end
        chk("wd_clear_len", n, WD);
        chk("wd_fault_phase", int'(phase), 15);

        en = 1'b0;
        reset = 1'b1;
        stuck_yel_a = 1'b0;
        @(negedge clklf);
        reset = 1'b0;
        en = 1'b1;
        wait_phase("drop_a_green", 2, 50);
        run_green(-1, dur);
        chk("drop_a_green_dwell", dur, MAX_G);
        wait_phase("drop_allred", 4, 50);
        req_b = 1'b1;
        en = 1'b0;
        @(negedge clklf);
        req_b = 1'b0;
        @(negedge clklf);
        chk("drop_idle_phase", int'(phase), 0);
        chk("drop_en_off", int'({en_a, en_b}), 0);
        en = 1'b1;
        wait_phase("reen_init", 1, 20);
        wait_phase("reen_a_green", 2, 20);
        run_green(-1, dur);
        chk("pend_b_retained", dur, MIN_G);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
